// File: rtl/cpu_types_pkg.sv
// Shared CPU/memory types: RAM handshake state, data word, responder FSM states.
`timescale 1ns/1ps
package cpu_types_pkg;
    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        IACC   = 2'd1,
        DACC   = 2'd2,
        HALTED = 2'd3
    } resp_state_t;
endpackage

// File: rtl/resp_timeout_ctr.sv
// 8-bit saturating wait counter; expired flags the last permitted wait cycle.
`timescale 1ns/1ps
module resp_timeout_ctr #(
    parameter int LIMIT = 64
) (
    input  logic       CLK,
    input  logic       nRST,
    input  logic       clear,
    input  logic       inc,
    output logic [7:0] count,
    output logic       expired
);
    localparam int unsigned LIMIT_M1 = (LIMIT > 0) ? LIMIT - 1 : 0;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST)
            count <= '0;
        else if (clear)
            count <= '0;
        else if (inc && count != 8'hFF)
            count <= count + 8'd1;
    end

    // True while the current wait cycle is the one that reaches LIMIT.
    assign expired = (32'(count) >= LIMIT_M1);
endmodule

// File: rtl/dp_mem_responder.sv
// Arbitrates datapath instruction/data requests onto a single RAM port.
// Optional build macro HIT_COUNT_EN adds ihit_count/dhit_count outputs.
`timescale 1ns/1ps
module dp_mem_responder
    import cpu_types_pkg::*;
#(
    parameter int TIMEOUT = 64
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        halt,
    input  logic        imemREN,
    input  word_t       imemaddr,
    input  logic        dmemREN,
    input  logic        dmemWEN,
    input  word_t       dmemaddr,
    input  word_t       dmemstore,
    output logic        ihit,
    output word_t       imemload,
    output logic        dhit,
    output word_t       dmemload,
    output logic        flushed,
    output logic        err,
    output logic        ramREN,
    output logic        ramWEN,
    output word_t       ramaddr,
    output word_t       ramstore,
    input  word_t       ramload,
    input  ramstate_t   ramstate
`ifdef HIT_COUNT_EN
    ,
    output logic [31:0] ihit_count,
    output logic [31:0] dhit_count
`endif
);
    // state  | meaning
    // IDLE   | no access in flight, RAM strobes low
    // IACC   | instruction fetch on the RAM port
    // DACC   | data load/store on the RAM port
    // HALTED | drained after halt, flushed high until reset

    resp_state_t state, next_state;
    logic        wait_cyc, set_err, ctr_clear, expired;
    logic [7:0]  wait_count;
    logic        dreq;

    assign dreq = dmemREN | dmemWEN;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state <= IDLE;
            err   <= 1'b0;
        end else begin
            state <= next_state;
            if (set_err)
                err <= 1'b1;
        end
    end

    always_comb begin
        next_state = state;
        ihit       = 1'b0;
        dhit       = 1'b0;
        ramREN     = 1'b0;
        ramWEN     = 1'b0;
        ramaddr    = '0;
        ramstore   = '0;
        wait_cyc   = 1'b0;
        set_err    = 1'b0;
        case (state)
            IDLE: begin
                if (halt)
                    next_state = HALTED;
                else if (dreq)
                    next_state = DACC;
                else if (imemREN)
                    next_state = IACC;
            end
            IACC: begin
                // A fetch is speculative, so halt abandons it outright.
                if (halt)
                    next_state = HALTED;
                else if (!imemREN)
                    next_state = IDLE;
                else begin
                    ramREN  = 1'b1;
                    ramaddr = imemaddr;
                    if (ramstate == ACCESS) begin
                        ihit       = 1'b1;
                        next_state = IDLE;
                    end else begin
                        wait_cyc = 1'b1;
                        if (expired) begin
                            set_err    = 1'b1;
                            next_state = IDLE;
                        end
                    end
                end
            end
            DACC: begin
                if (!dreq)
                    next_state = halt ? HALTED : IDLE;
                else begin
                    ramaddr  = dmemaddr;
                    ramstore = dmemstore;
                    ramWEN   = dmemWEN;
                    ramREN   = dmemREN & ~dmemWEN;
                    if (ramstate == ACCESS) begin
                        dhit       = 1'b1;
                        next_state = halt ? HALTED : IDLE;
                    end else begin
                        wait_cyc = 1'b1;
                        if (expired) begin
                            set_err    = 1'b1;
                            next_state = halt ? HALTED : IDLE;
                        end
                    end
                end
            end
            HALTED: next_state = HALTED;
            default: next_state = IDLE;
        endcase
    end

    assign ctr_clear = (state != next_state) || !(state == IACC || state == DACC);

    resp_timeout_ctr #(.LIMIT(TIMEOUT)) u_timeout_ctr (
        .CLK     (CLK),
        .nRST    (nRST),
        .clear   (ctr_clear),
        .inc     (wait_cyc),
        .count   (wait_count),
        .expired (expired)
    );

    assign flushed  = (state == HALTED);
    assign imemload = ramload;
    assign dmemload = ramload;

`ifdef HIT_COUNT_EN
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            ihit_count <= '0;
            dhit_count <= '0;
        end else begin
            if (ihit)
                ihit_count <= ihit_count + 32'd1;
            if (dhit)
                dhit_count <= dhit_count + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_dp_mem_responder.sv
// Directed self-checking bench for dp_mem_responder (hit counters checked when HIT_COUNT_EN is defined).
`timescale 1ns/1ps
module tb_dp_mem_responder;
    import cpu_types_pkg::*;

    logic      CLK = 1'b0;
    logic      nRST;
    logic      halt, imemREN, dmemREN, dmemWEN;
    word_t     imemaddr, dmemaddr, dmemstore, ramload;
    ramstate_t ramstate;
    logic      ihit, dhit, flushed, err, ramREN, ramWEN;
    word_t     imemload, dmemload, ramaddr, ramstore;
`ifdef HIT_COUNT_EN
    logic [31:0] ihit_count, dhit_count;
`endif

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    dp_mem_responder #(.TIMEOUT(64)) dut (
        .CLK       (CLK),
        .nRST      (nRST),
        .halt      (halt),
        .imemREN   (imemREN),
        .imemaddr  (imemaddr),
        .dmemREN   (dmemREN),
        .dmemWEN   (dmemWEN),
        .dmemaddr  (dmemaddr),
        .dmemstore (dmemstore),
        .ihit      (ihit),
        .imemload  (imemload),
        .dhit      (dhit),
        .dmemload  (dmemload),
        .flushed   (flushed),
        .err       (err),
        .ramREN    (ramREN),
        .ramWEN    (ramWEN),
        .ramaddr   (ramaddr),
        .ramstore  (ramstore),
        .ramload   (ramload),
        .ramstate  (ramstate)
`ifdef HIT_COUNT_EN
        ,
        .ihit_count(ihit_count),
        .dhit_count(dhit_count)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_inputs();
        halt = 0; imemREN = 0; dmemREN = 0; dmemWEN = 0;
        imemaddr = '0; dmemaddr = '0; dmemstore = '0;
        ramload = '0; ramstate = FREE;
    endtask

    task automatic do_reset();
        idle_inputs();
        #2 nRST = 0;
        #3 nRST = 1;
        cyc();
    endtask

    initial begin
        nRST = 0;
        idle_inputs();
        #12;
        check("rst_ihit", 32'(ihit), 0);
        check("rst_dhit", 32'(dhit), 0);
        check("rst_ramREN", 32'(ramREN), 0);
        check("rst_ramWEN", 32'(ramWEN), 0);
        check("rst_flushed", 32'(flushed), 0);
        check("rst_err", 32'(err), 0);
        check("rst_ramaddr", ramaddr, 0);
        @(negedge CLK) nRST = 1;
        cyc();

        // Fetch with two BUSY cycles; ACCESS seen in IDLE must not hit.
        imemREN = 1; imemaddr = 32'h0; ramstate = ACCESS; ramload = 32'h3C010001;
        #1;
        check("idle_no_ihit", 32'(ihit), 0);
        check("idle_ramREN", 32'(ramREN), 0);
        cyc();
        ramstate = BUSY; #1;
        check("iacc_ramREN", 32'(ramREN), 1);
        check("iacc_busy1_ihit", 32'(ihit), 0);
        cyc();
        #1 check("iacc_busy2_ihit", 32'(ihit), 0);
        cyc();
        ramstate = ACCESS; #1;
        check("iacc_ihit", 32'(ihit), 1);
        check("imemload", imemload, 32'h3C010001);
        cyc();
        imemREN = 0; ramstate = FREE; #1;
        check("after_ihit_pulse", 32'(ihit), 0);
        check("after_ihit_ramREN", 32'(ramREN), 0);

        // Simultaneous fetch and store: data goes first, write wins over read.
        imemREN = 1; imemaddr = 32'h40;
        dmemWEN = 1; dmemREN = 1; dmemaddr = 32'h100; dmemstore = 32'hDEADBEEF;
        cyc();
        #1;
        check("dacc_ramWEN", 32'(ramWEN), 1);
        check("dacc_ramREN", 32'(ramREN), 0);
        check("dacc_ramaddr", ramaddr, 32'h100);
        check("dacc_ramstore", ramstore, 32'hDEADBEEF);
        check("dacc_free_dhit", 32'(dhit), 0);
        ramstate = ACCESS; #1;
        check("dacc_dhit", 32'(dhit), 1);
        check("dacc_no_ihit", 32'(ihit), 0);
        cyc();
        dmemWEN = 0; dmemREN = 0; ramstate = FREE; #1;
        check("idle_ramaddr_zero", ramaddr, 0);
        check("idle_ramstore_zero", ramstore, 0);
        cyc();
        #1;
        check("then_iacc_ramREN", 32'(ramREN), 1);
        check("then_iacc_ramaddr", ramaddr, 32'h40);
        // Withdrawn fetch: no hit even with ACCESS, strobes low.
        imemREN = 0; ramstate = ACCESS; #1;
        check("withdraw_ihit", 32'(ihit), 0);
        check("withdraw_ramREN", 32'(ramREN), 0);
        cyc();
        ramstate = FREE; imemREN = 1; #1;
        check("withdraw_idle", 32'(ramREN), 0);

        // Timeout: 64 BUSY cycles in IACC.
        ramstate = BUSY;
        cyc();
        for (int i = 0; i < 64; i++) begin
            #1;
            if (i == 63) begin
                check("to_last_ramREN", 32'(ramREN), 1);
                check("to_last_err", 32'(err), 0);
            end
            if (ihit) check("to_ihit", 32'(ihit), 0);
            cyc();
        end
        #1;
        check("to_err", 32'(err), 1);
        check("to_idle_ramREN", 32'(ramREN), 0);
        check("to_ihit_final", 32'(ihit), 0);
        imemREN = 0; ramstate = FREE;
        cyc();
        #1 check("to_err_sticky", 32'(err), 1);

        // Asynchronous reset in the middle of a data read.
        dmemREN = 1; dmemaddr = 32'h300; ramstate = BUSY;
        cyc();
        #1 check("rstmid_ramREN", 32'(ramREN), 1);
        #1 nRST = 0;
        #1;
        check("rstmid_ramREN_low", 32'(ramREN), 0);
        check("rstmid_ramaddr", ramaddr, 0);
        check("rstmid_err", 32'(err), 0);
        check("rstmid_flushed", 32'(flushed), 0);
        dmemREN = 0;
        #2 nRST = 1;
        cyc();
        #1 check("rstmid_idle", 32'(ramREN), 0);

        // Halt during fetch aborts without a hit.
        imemREN = 1; ramstate = BUSY;
        cyc();
        halt = 1; ramstate = ACCESS; #1;
        check("ihalt_no_ihit", 32'(ihit), 0);
        check("ihalt_ramREN", 32'(ramREN), 0);
        cyc();
        #1 check("ihalt_flushed", 32'(flushed), 1);
        do_reset();
        #1 check("reset_clears_flushed", 32'(flushed), 0);

        // Halt during data read at 0x200: the load completes, then drain.
        dmemREN = 1; dmemaddr = 32'h200; ramstate = BUSY; ramload = 32'h12345678;
        cyc();
        halt = 1; #1;
        check("dhalt_ramREN", 32'(ramREN), 1);
        check("dhalt_ramaddr", ramaddr, 32'h200);
        check("dhalt_not_flushed", 32'(flushed), 0);
        cyc();
        ramstate = ACCESS; #1;
        check("dhalt_dhit", 32'(dhit), 1);
        check("dhalt_dmemload", dmemload, 32'h12345678);
        cyc();
        dmemREN = 0; imemREN = 1; #1;
        check("halted_flushed", 32'(flushed), 1);
        check("halted_ramREN", 32'(ramREN), 0);
        check("halted_ihit", 32'(ihit), 0);
        halt = 0;
        cyc(); cyc();
        #1;
        check("halted_ignores_fetch", 32'(ramREN), 0);
        check("halted_sticky", 32'(flushed), 1);
        check("halted_ramaddr", ramaddr, 0);

`ifdef HIT_COUNT_EN
        do_reset();
        check("cnt_rst_i", ihit_count, 0);
        check("cnt_rst_d", dhit_count, 0);
        for (int k = 0; k < 3; k++) begin
            imemREN = 1; ramstate = ACCESS;
            cyc(); cyc();
            imemREN = 0; ramstate = FREE;
            cyc();
        end
        for (int k = 0; k < 2; k++) begin
            dmemREN = 1; ramstate = ACCESS;
            cyc(); cyc();
            dmemREN = 0; ramstate = FREE;
            cyc();
        end
        check("ihit_count", ihit_count, 3);
        check("dhit_count", dhit_count, 2);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end
endmodule
